// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle core: control states, ALU operation codes,
// instruction fields and datapath mux selects.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP
    } state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Control <-> datapath signal bundle; master is the control FSM, slave the datapath.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_control;
    logic       illegal;
    logic       instr_done;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, alu_control, illegal, instr_done
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
               alu_src_a, alu_src_b, pc_src, alu_control, illegal, instr_done
    );
endinterface

// File: rtl/alu_decoder.sv
// R-type funct to ALU operation code; valid_o flags a supported funct.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [3:0] alu_control_o,
    output logic       valid_o
);
    always_comb begin
        alu_control_o = ALU_ADD;
        valid_o       = 1'b1;
        case (funct_i)
            FN_ADD:  alu_control_o = ALU_ADD;
            FN_SUB:  alu_control_o = ALU_SUB;
            FN_AND:  alu_control_o = ALU_AND;
            FN_OR:   alu_control_o = ALU_OR;
            FN_SLT:  alu_control_o = ALU_SLT;
            FN_NOR:  alu_control_o = ALU_NOR;
            default: valid_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle core: registered state, outputs decoded from the
// state and qualified by mem_ready / zero; all outputs forced to idle while reset is high.
module multicycle_control
    import cpu_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    multicycle_control_if.master        bus
);
    state_e     state_q, state_d;
    logic [3:0] funct_alu;
    logic       funct_ok;
    logic       op_ok;

    alu_decoder u_alu_dec (
        .funct_i       (bus.funct),
        .alu_control_o (funct_alu),
        .valid_o       (funct_ok)
    );

    always_comb begin
        case (bus.opcode)
            OP_RTYPE:                              op_ok = funct_ok;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J:   op_ok = 1'b1;
            default:                               op_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!op_ok) begin
                    state_d = S_FETCH;
                end else begin
                    case (bus.opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECUTE;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDIEX;
                        OP_J:         state_d = S_JUMP;
                        default:      state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:  state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (bus.mem_ready) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Outputs are combinational so FETCH/MEMWR/BRANCH can qualify on same-cycle inputs.
    always_comb begin
        bus.pc_en       = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = SRCB_B;
        bus.pc_src      = PCSRC_ALU;
        bus.alu_control = ALU_ADD;
        bus.illegal     = 1'b0;
        bus.instr_done  = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.alu_src_b = SRCB_FOUR;
                    bus.ir_write  = bus.mem_ready;
                    bus.pc_en     = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.alu_src_b  = SRCB_IMMSH;
                    bus.illegal    = !op_ok;
                    bus.instr_done = !op_ok;
                end
                S_MEMADR, S_ADDIEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEMRD: bus.iord = 1'b1;
                S_MEMWB: begin
                    bus.mem_to_reg = 1'b1;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    bus.iord       = 1'b1;
                    bus.mem_write  = 1'b1;
                    bus.instr_done = bus.mem_ready;
                end
                S_EXECUTE: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_control = funct_alu;
                end
                S_ALUWB: begin
                    bus.reg_dst    = 1'b1;
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    bus.alu_src_a   = 1'b1;
                    bus.alu_control = ALU_SUB;
                    bus.pc_src      = PCSRC_ALUOUT;
                    bus.pc_en       = bus.zero;
                    bus.instr_done  = 1'b1;
                end
                S_ADDIWB: begin
                    bus.reg_write  = 1'b1;
                    bus.instr_done = 1'b1;
                end
                S_JUMP: begin
                    bus.pc_src     = PCSRC_JUMP;
                    bus.pc_en      = 1'b1;
                    bus.instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: the driver derives per-instruction expectations from the ISA rules,
// and a negedge monitor tallies DUT activity and compares at each instr_done.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam int K_ILL = 0, K_R = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ADDI = 5, K_J = 6;

    typedef struct {
        int len;
        int ir_wr;
        int pc_en;
        int rw;
        int mw;
        int iord;
        int ill;
        int imm_b;
        int dec_b;
        int alu;
        int wb;
        int pcs;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic int ref_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            6'b100111: return 12;
            default:   return -1;
        endcase
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'b000000: return (ref_alu(f) >= 0) ? K_R : K_ILL;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            default:   return K_ILL;
        endcase
    endfunction

    // Drive one instruction: fs stall cycles in FETCH, ms stall cycles in the memory state.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fs, input int ms);
        exp_t e;
        bit   sched[$];
        int   kind;
        kind = classify(op, fn);
        e = '{len: 0, ir_wr: 1, pc_en: 1, rw: 0, mw: 0, iord: 0, ill: 0,
              imm_b: 0, dec_b: 1, alu: -1, wb: 3, pcs: 3};
        repeat (fs) sched.push_back(1'b0);
        sched.push_back(1'b1);
        sched.push_back(1'($urandom));
        case (kind)
            K_ILL: e.ill = 1;
            K_J: begin
                sched.push_back(1'($urandom));
                e.pc_en++;
                e.pcs = 2;
            end
            K_BEQ: begin
                sched.push_back(1'($urandom));
                e.alu = 6;
                if (z) begin
                    e.pc_en++;
                    e.pcs = 1;
                end
            end
            K_R: begin
                repeat (2) sched.push_back(1'($urandom));
                e.alu = ref_alu(fn);
                e.rw  = 1;
                e.wb  = 2;
            end
            K_ADDI: begin
                repeat (2) sched.push_back(1'($urandom));
                e.rw    = 1;
                e.imm_b = 1;
                e.wb    = 0;
            end
            default: begin
                sched.push_back(1'($urandom));
                repeat (ms) sched.push_back(1'b0);
                sched.push_back(1'b1);
                e.imm_b = 1;
                e.iord  = ms + 1;
                if (kind == K_LW) begin
                    sched.push_back(1'($urandom));
                    e.rw = 1;
                    e.wb = 1;
                end else begin
                    e.mw = ms + 1;
                end
            end
        endcase
        e.len = sched.size();
        exp_q.push_back(e);
        foreach (sched[k]) begin
            bus.opcode    = op;
            bus.funct     = fn;
            bus.zero      = z;
            bus.mem_ready = sched[k];
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor tallies
    int   c_len, c_ir, c_pc, c_rw, c_mw, c_iord, c_ill, c_imm, c_dec, o_alu, o_wb, o_pcs;
    exp_t me;

    task automatic clr();
        c_len = 0; c_ir = 0; c_pc = 0; c_rw = 0; c_mw = 0; c_iord = 0;
        c_ill = 0; c_imm = 0; c_dec = 0; o_alu = -1; o_wb = 3; o_pcs = 3;
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            clr();
        end else begin
            c_len++;
            c_ir   += int'(bus.ir_write);
            c_pc   += int'(bus.pc_en);
            c_rw   += int'(bus.reg_write);
            c_mw   += int'(bus.mem_write);
            c_iord += int'(bus.iord);
            c_ill  += int'(bus.illegal);
            if (bus.alu_src_b == 2'b10) c_imm++;
            if (bus.alu_src_b == 2'b11) c_dec++;
            if (bus.alu_src_a && bus.alu_src_b == 2'b00) o_alu = int'(bus.alu_control);
            if (bus.reg_write) o_wb = int'({bus.reg_dst, bus.mem_to_reg});
            if (bus.pc_en && !bus.ir_write) o_pcs = int'(bus.pc_src);
            if (bus.instr_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_instr_done", 1, 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("cycles",       c_len,  me.len);
                    chk("ir_write_cyc", c_ir,   me.ir_wr);
                    chk("pc_en_cyc",    c_pc,   me.pc_en);
                    chk("reg_write_cyc",c_rw,   me.rw);
                    chk("mem_write_cyc",c_mw,   me.mw);
                    chk("iord_cyc",     c_iord, me.iord);
                    chk("illegal_cyc",  c_ill,  me.ill);
                    chk("srcb_imm_cyc", c_imm,  me.imm_b);
                    chk("srcb_dec_cyc", c_dec,  me.dec_b);
                    chk("alu_op",       o_alu,  me.alu);
                    chk("wb_sel",       o_wb,   me.wb);
                    chk("pc_src",       o_pcs,  me.pcs);
                end
                clr();
            end
        end
    end

    logic [5:0] fn_tab [6];

    initial begin
        int sel;
        logic [5:0] op, fn;
        fn_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        clr();
        reset = 1'b1;
        bus.opcode = 6'b000010;
        bus.funct = 6'b000000;
        bus.zero = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc_en",       int'(bus.pc_en), 0);
        chk("rst_ir_write",    int'(bus.ir_write), 0);
        chk("rst_reg_write",   int'(bus.reg_write), 0);
        chk("rst_mem_write",   int'(bus.mem_write), 0);
        chk("rst_iord",        int'(bus.iord), 0);
        chk("rst_illegal",     int'(bus.illegal), 0);
        chk("rst_instr_done",  int'(bus.instr_done), 0);
        chk("rst_alu_control", int'(bus.alu_control), 2);
        chk("rst_alu_src_b",   int'(bus.alu_src_b), 0);
        chk("rst_pc_src",      int'(bus.pc_src), 0);

        // Abort an R add in EXECUTE with a one-cycle reset.
        @(posedge clk); #1;
        reset = 1'b0;
        bus.opcode = 6'b000000;
        bus.funct = 6'b100000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_in_execute", int'(bus.alu_src_a), 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_reg_write", int'(bus.reg_write), 0);
        chk("abort_alu_ctl",   int'(bus.alu_control), 2);
        chk("abort_src_a",     int'(bus.alu_src_a), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("post_abort_fetch_srcb", int'(bus.alu_src_b), 1);
        chk("post_abort_ir_write",   int'(bus.ir_write), 0);
        chk("post_abort_reg_write",  int'(bus.reg_write), 0);
        chk("post_abort_alu_ctl",    int'(bus.alu_control), 2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(6'b000000, 6'b100111, 1'b0, 0, 0);
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b101011, 6'b000000, 1'b0, 2, 0);
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
        run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);

        repeat (300) begin
            sel = $urandom_range(0, 7);
            fn  = 6'($urandom);
            case (sel)
                0: begin op = 6'b000000; fn = fn_tab[$urandom_range(0, 5)]; end
                1: op = 6'b000000;
                2: op = 6'b100011;
                3: op = 6'b101011;
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, 1'($urandom),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle 32-bit processor core. Sequences each instruction through fetch, decode, execute, memory and write-back steps. Drives every datapath mux select and write enable. Produces the 4-bit operation code consumed directly by the ALU, so it sits immediately upstream of the ALU and owns all ALU operation selection.

## Interface
Parameters: none; all encodings live in the shared package.

Ports:
- `clk`  in  1  single core clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  6  instruction bits [31:26], taken from the instruction register
- `funct`  in  6  instruction bits [5:0], taken from the instruction register
- `zero`  in  1  ALU result == 0
- `mem_ready`  in  1  memory access completes this cycle
- `pc_en`  out  1  PC register load enable
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction register load
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd
- `mem_to_reg`  out  1  write-back data: 0 = ALUOut, 1 = MDR
- `reg_write`  out  1  register file write enable
- `alu_src_a`  out  1  ALU left operand: 0 = PC, 1 = A
- `alu_src_b`  out  2  ALU right operand: 00 = B, 01 = 4, 10 = sext(imm), 11 = sext(imm)<<2
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_control`  out  4  ALU operation code
- `illegal`  out  1  one-cycle pulse on an unsupported opcode/funct
- `instr_done`  out  1  one-cycle pulse in the last cycle of each instruction

## Operation
- Moore FSM with a registered state. Outputs are a combinational decode of the state, plus the `mem_ready`/`zero` qualifiers listed below.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Supported R-type funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010, nor 100111.
- States and outputs. Any output not listed is 0; `alu_control` defaults to ADD.
  - FETCH: alu_src_b=01, ADD; ir_write=pc_en=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
  - DECODE: alu_src_b=11, ADD (precomputes the branch target). Next state by opcode: lw/sw→MEMADR, R→EXECUTE, beq→BRANCH, addi→ADDIEX, j→JUMP.
    - Unknown opcode or unknown R funct: illegal=1, instr_done=1, next state FETCH.
  - MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next: lw→MEMRD, sw→MEMWR.
  - MEMRD: iord=1. Holds until mem_ready, then goes to MEMWB.
  - MEMWB: mem_to_reg=1, reg_write=1, instr_done=1. Next: FETCH.
  - MEMWR: iord=1, mem_write=1. mem_write stays high while waiting. On mem_ready: instr_done=1, next state FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_control=decode(funct). Next: ALUWB.
  - ALUWB: reg_dst=1, reg_write=1, instr_done=1. Next: FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_en=zero, instr_done=1. Next: FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, ADD. Next: ADDIWB.
  - ADDIWB: reg_write=1, instr_done=1. Next: FETCH.
  - JUMP: pc_src=10, pc_en=1, instr_done=1. Next: FETCH.
- `opcode`/`funct` are stable from DECODE through the end of the instruction; the block does not latch them.

## Timing
- Reset:
  - While reset=1: every enable/strobe output, illegal and instr_done are 0; alu_control=0010; all mux selects are 0.
  - The first rising edge with reset=1 sets the state to FETCH.
  - Reset asserted mid-instruction aborts it. No write enable fires in the reset cycle.
- Latency with mem_ready=1 at the first opportunity:
  - lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; illegal 2 cycles.
  - Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- The PC update and IR load in FETCH occur on the same edge that leaves FETCH.
- In BRANCH, `zero` is sampled in the same cycle; a taken branch loads PC on that edge.
- `instr_done` is high for exactly one cycle per instruction, coincident with its final state.

## Structure
- Package `cpu_pkg`:
  - state enum
  - ALU operation code constants (shared with the ALU)
  - opcode and funct constants
  - `alu_src_b` and `pc_src` select encodings
- Sub-module `alu_decoder`: combinational funct→alu_control plus a valid flag. Used in EXECUTE for alu_control, and in DECODE for the illegal-funct check.

## Test plan
- Reset mid-EXECUTE of an R add: reset=1 for one cycle → reg_write never rises; next cycle state=FETCH; alu_control=0010.
- R-type funct 100111 (nor), mem_ready=1: EXECUTE shows alu_control=1100 and alu_src_b=00; ALUWB shows reg_write=1, reg_dst=1; 4 cycles total.
- lw with mem_ready held 0 for 3 cycles in MEMRD: iord=1 throughout the stall; MEMWB reached on the cycle after mem_ready=1; total 8 cycles; instr_done pulses once.
- beq with zero=1, then beq with zero=0: pc_en=1 with pc_src=01 in the first case; pc_en=0 in the second; alu_control=0110 in both.
- sw with mem_ready=0 for 2 cycles in FETCH: ir_write and pc_en stay 0 until mem_ready=1; MEMWR asserts mem_write=1, iord=1; total 6 cycles.
- opcode 111111, then R with funct 000000: each gives illegal=1 for one cycle in DECODE, reg_write and mem_write never asserted, and a return to FETCH.
